puf_ro_ctrl: RTL and testbench

PUF_RO_CTRL -- requirements
Module: puf_ro_ctrl

---
 rtl/puf_ro_ctrl.sv | 150 +++++++++++++++
 tb/tb_puf_ro_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_ro_ctrl.sv
// Ring-oscillator PUF controller: compares edge counts of RO pairs 2k/2k+1 into one response bit each.
// Optional build macro PUF_RO_CTRL_MARGIN_EN adds the o_unstable low-margin flags.
`timescale 1ns/1ps
module puf_ro_ctrl #(
    parameter int N_RO       = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int WIN_CYC    = 64,
    parameter int MARGIN     = 2,
    localparam int RESP_W    = N_RO / 2,
    localparam int SEL_W     = ($clog2(N_RO) < 1) ? 1 : $clog2(N_RO)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_ro_a,
    input  logic              i_ro_b,
    output logic              o_ro_en,
    output logic [SEL_W-1:0]  o_sel_a,
    output logic [SEL_W-1:0]  o_sel_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [RESP_W-1:0] o_resp
`ifdef PUF_RO_CTRL_MARGIN_EN
    ,
    output logic [RESP_W-1:0] o_unstable
`endif
);

    localparam int KW   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int TMAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    if (N_RO < 2 || (N_RO % 2) != 0 || SETTLE_CYC < 1 || WIN_CYC < 1 || MARGIN < 0) begin : g_bad_param
        $error("puf_ro_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_COUNT   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_tmr;
    logic [KW-1:0]     r_k;
    logic [CNT_W-1:0]  r_cnt_a;
    logic [CNT_W-1:0]  r_cnt_b;
    logic [RESP_W-1:0] r_resp;
    logic              r_a_s1, r_a_s2, r_a_e;
    logic              r_b_s1, r_b_s2, r_b_e;

    logic w_rise_a, w_rise_b;
    logic w_settle_last, w_count_last, w_k_last;
    logic w_accept, w_enter_settle;

    assign w_rise_a       = r_a_s2 & ~r_a_e;
    assign w_rise_b       = r_b_s2 & ~r_b_e;
    assign w_settle_last  = (r_tmr == TW'(SETTLE_CYC - 1));
    assign w_count_last   = (r_tmr == TW'(WIN_CYC - 1));
    assign w_k_last       = (r_k == KW'(RESP_W - 1));
    assign w_accept       = (r_state == S_IDLE) && i_start;
    assign w_enter_settle = (w_state_nxt == S_SETTLE) && (r_state != S_SETTLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start)       w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_settle_last) w_state_nxt = S_COUNT;
            S_COUNT:   if (w_count_last)  w_state_nxt = S_COMPARE;
            S_COMPARE: w_state_nxt = w_k_last ? S_DONE : S_SETTLE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: RO enable follows the state so reset kills it on the same edge
    always_comb begin
        o_ro_en = (r_state == S_SETTLE) || (r_state == S_COUNT);
        o_busy  = (r_state != S_IDLE);
        o_done  = (r_state == S_DONE);
    end

    assign o_sel_a = SEL_W'({r_k, 1'b0});
    assign o_sel_b = SEL_W'({r_k, 1'b1});
    assign o_resp  = r_resp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_s1 <= 1'b0; r_a_s2 <= 1'b0; r_a_e <= 1'b0;
            r_b_s1 <= 1'b0; r_b_s2 <= 1'b0; r_b_e <= 1'b0;
        end else begin
            r_a_s1 <= i_ro_a; r_a_s2 <= r_a_s1; r_a_e <= r_a_s2;
            r_b_s1 <= i_ro_b; r_b_s2 <= r_b_s1; r_b_e <= r_b_s2;
        end
    end

    // Phase timer restarts on every state change
    always_ff @(posedge i_clk) begin
        if (i_rst)                          r_tmr <= '0;
        else if (w_state_nxt != r_state)    r_tmr <= '0;
        else if (o_ro_en)                   r_tmr <= r_tmr + TW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                                 r_k <= '0;
        else if (w_accept)                         r_k <= '0;
        else if (r_state == S_COMPARE && !w_k_last) r_k <= r_k + KW'(1);
    end

    // Saturating edge counters, live only inside the count window
    always_ff @(posedge i_clk) begin
        if (i_rst || w_enter_settle) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (r_state == S_COUNT) begin
            if (w_rise_a && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + CNT_W'(1);
            if (w_rise_b && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept)          r_resp <= '0;
        else if (r_state == S_COMPARE)  r_resp[r_k] <= (r_cnt_a > r_cnt_b);
    end

`ifdef PUF_RO_CTRL_MARGIN_EN
    logic [RESP_W-1:0] r_unstable;
    logic [CNT_W-1:0]  w_diff;

    assign w_diff     = (r_cnt_a > r_cnt_b) ? (r_cnt_a - r_cnt_b) : (r_cnt_b - r_cnt_a);
    assign o_unstable = r_unstable;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept)         r_unstable <= '0;
        else if (r_state == S_COMPARE) r_unstable[r_k] <= ({1'b0, w_diff} < (CNT_W + 1)'(MARGIN));
    end
`endif

endmodule

// File: tb/tb_puf_ro_ctrl.sv
// Directed bench for puf_ro_ctrl with a per-cycle timeline model and literal spot checks.
`timescale 1ns/1ps
module tb_puf_ro_ctrl;
    localparam int RW  = 2;
    localparam int PER = 8 + 64 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sat_start = 1'b0;
    logic ro_en, busy, done;
    logic [1:0] sel_a, sel_b;
    logic [RW-1:0] resp;
    logic sat_ro_en, sat_busy, sat_done;
    logic [0:0] sat_sel_a, sat_sel_b, sat_resp;
`ifdef PUF_RO_CTRL_MARGIN_EN
    logic [RW-1:0] unstable;
    logic [0:0]    sat_unstable;
`endif

    int half [4] = '{20, 30, 40, 15};
    int sat_half [2] = '{10, 50};
    logic [3:0] ro_v = '0;
    logic [1:0] sat_ro_v = '0;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    // RO waveforms derived from absolute time; transitions never coincide with clock edges
    always #1 begin
        longint t;
        t = $time;
        for (int g = 0; g < 4; g++)
            ro_v[g] = (t < 2) ? 1'b0 : ((((t - 2) / half[g]) % 2) != 0);
        for (int g = 0; g < 2; g++)
            sat_ro_v[g] = (t < 2) ? 1'b0 : ((((t - 2) / sat_half[g]) % 2) != 0);
    end

    puf_ro_ctrl #(.N_RO(4), .CNT_W(16), .SETTLE_CYC(8), .WIN_CYC(64), .MARGIN(2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_ro_a(ro_v[sel_a]), .i_ro_b(ro_v[sel_b]),
        .o_ro_en(ro_en), .o_sel_a(sel_a), .o_sel_b(sel_b),
        .o_busy(busy), .o_done(done), .o_resp(resp)
`ifdef PUF_RO_CTRL_MARGIN_EN
        , .o_unstable(unstable)
`endif
    );

    puf_ro_ctrl #(.N_RO(2), .CNT_W(4), .SETTLE_CYC(8), .WIN_CYC(64), .MARGIN(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_start(sat_start),
        .i_ro_a(sat_ro_v[sat_sel_a]), .i_ro_b(sat_ro_v[sat_sel_b]),
        .o_ro_en(sat_ro_en), .o_sel_a(sat_sel_a), .o_sel_b(sat_sel_b),
        .o_busy(sat_busy), .o_done(sat_done), .o_resp(sat_resp)
`ifdef PUF_RO_CTRL_MARGIN_EN
        , .o_unstable(sat_unstable)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Timeline model: a run is RW bit slots of PER cycles plus one done cycle
    logic          m_en = 1'b0;
    logic          m_run = 1'b0;
    int            m_rel = 0;
    int            m_k = 0;
    logic [RW-1:0] m_resp = '0, m_uns = '0, m_expb = '0, m_expu = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_resp = '0; m_uns = '0; m_k = 0;
        end else if (m_run) begin
            m_rel++;
            if (m_rel % PER == 0 && m_rel <= RW * PER) begin
                m_resp[m_rel / PER - 1] = m_expb[m_rel / PER - 1];
                m_uns[m_rel / PER - 1]  = m_expu[m_rel / PER - 1];
            end
            m_k = (m_rel / PER < RW) ? m_rel / PER : RW - 1;
            if (m_rel > RW * PER) m_run = 1'b0;
        end else if (start) begin
            m_run = 1'b1; m_rel = 0; m_resp = '0; m_uns = '0; m_k = 0;
            for (int b = 0; b < RW; b++) begin
                m_expb[b] = (half[2*b] < half[2*b+1]);
                m_expu[b] = (half[2*b] == half[2*b+1]);
            end
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("busy",  32'(busy),  32'(m_run));
            chk("ro_en", 32'(ro_en), 32'(m_run && m_rel < RW * PER && (m_rel % PER) < PER - 1));
            chk("done",  32'(done),  32'(m_run && m_rel == RW * PER));
            chk("sel",   {sel_a, sel_b}, 32'({2'(2 * m_k), 2'(2 * m_k + 1)}));
            chk("resp",  32'(resp),  32'(m_resp));
`ifdef PUF_RO_CTRL_MARGIN_EN
            chk("unstable", 32'(unstable), 32'(m_uns));
`endif
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk); cyc++;
        end
    endtask

    initial begin
        int cyc, n_done, n_sat_done;
        logic en_seen;

        repeat (3) @(negedge clk);
        m_en = 1'b1;
        chk("rst_sel_a", 32'(sel_a), 32'd0);
        chk("rst_sel_b", 32'(sel_b), 32'd1);
        chk("rst_resp",  32'(resp),  32'd0);
        chk("rst_outs",  {ro_en, busy, done}, 32'd0);
        rst = 1'b0;
        en_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (ro_en) en_seen = 1'b1;
        end
        chk("idle_ro_en", 32'(en_seen), 32'd0);

        // Pair0 A faster, pair1 B faster; saturating instance runs alongside
        @(negedge clk); start = 1'b1; sat_start = 1'b1;
        @(negedge clk); start = 1'b0; sat_start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (cyc == 40)  chk("sel_bit0", {sel_a, sel_b}, 32'h1);
            if (cyc == 110) chk("sel_bit1", {sel_a, sel_b}, 32'hB);
            if (cyc == 74)  chk("sat_done_resp", {sat_done, sat_resp}, 32'h3);
            if (done) break;
            @(negedge clk); cyc++;
        end
        chk("done_cycle", 32'(cyc), 32'd147);
        chk("resp_pairs", 32'(resp), 32'h1);
        @(negedge clk);
        chk("resp_hold", 32'(resp), 32'h1);

        // Identical ROs tie to 0
        half = '{20, 20, 20, 20};
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(cyc);
        chk("tie_done_cycle", 32'(cyc), 32'd147);
        chk("tie_resp", 32'(resp), 32'h0);
`ifdef PUF_RO_CTRL_MARGIN_EN
        chk("tie_unstable", 32'(unstable), 32'h3);
`endif

        // Starts while busy are dropped
        half = '{20, 30, 40, 15};
        repeat (5) @(negedge clk);
        pulse_start();
        n_done = 0;
        for (int c = 1; c < 300; c++) begin
            start = (c == 20 || c == 100);
            if (done) n_done++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_starts_one_done", 32'(n_done), 32'd1);
        chk("idle_after_run", 32'(busy), 32'd0);

        // Start held through DONE is taken on the following IDLE cycle
        pulse_start();
        wait_done(cyc);
        start = 1'b1;
        @(negedge clk);
        chk("idle_between", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("held_start_taken", 32'(busy), 32'd1);
        @(negedge clk);
        wait_done(cyc);
        chk("held_run_done", 32'(cyc), 32'd146);
        repeat (3) @(negedge clk);

        // Reset in COUNT of bit 1 aborts the run
        pulse_start();
        repeat (95) @(negedge clk);
        chk("pre_rst_count", {ro_en, 2'(sel_a)}, 32'h6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {ro_en, busy, done}, 32'd0);
        chk("abort_resp", 32'(resp), 32'd0);
        n_done = 0;
        n_sat_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) n_done++;
            if (sat_done) n_sat_done++;
        end
        chk("abort_no_done", 32'(n_done + n_sat_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
